hfrv_bus_bridge: RTL and testbench

- Memory/peripheral bus bridge between the HF-RISCV core and external memory inside the CPU verification top.
- Decodes core data/fetch accesses and inserts programmable memory wait states.
- Hosts four internal registers: debug character, exit/halt, cycle counter, interrupt status/mask.
- All bus traffic is visible on its ports, so the monitor sees fetches, data accesses and debug output.

---
 rtl/hfrv_bus_bridge.sv | 168 ++++++++++++++++
 tb/tb_hfrv_bus_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hfrv_bus_bridge.sv
// hfrv_bus_bridge
//   Bridge between the HF-RISCV core bus and external memory. Core accesses
//   below PERIPH_BASE go to memory with MEM_WAIT inserted wait states; accesses
//   at or above PERIPH_BASE hit a small internal register block (exit/halt,
//   debug character, cycle counter, interrupt status/mask) and never stall.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   core_addr/req/be/wdata   core request; be == 0 is a read; req held while stalled
//   core_rdata, core_stall   read data and wait-state stall back to the core
//   core_irq                 registered |(status & mask)
//   mem_addr/en/we/wdata     word-aligned memory request
//   mem_rdata                memory read data, combinational from mem_addr
//   ext_irq                  level interrupt sources, OR-ed into status each cycle
//   dbg_valid, dbg_char      one-cycle pulse + character on a debug-register write
//   halt, exit_code          sticky stop flag and last value written to EXIT
//
// Optional feature (macro HFRV_BUS_ALIGN_CHECK_EN): adds output bus_err, which
// flags a misaligned access on its completing cycle; such an access writes
// nothing and reads 32'hDEAD_BEEF.
//
// Handshake: an access is presented with core_req high and held stable until
// a cycle in which core_stall is low; that cycle completes the access (write
// committed at its closing edge, read data valid during it).
//
// CNT_INIT is the counter's reset value (0 in normal use).

module hfrv_bus_bridge #(
  parameter int          MEM_WAIT    = 1,
  parameter logic [31:0] PERIPH_BASE = 32'hE000_0000,
  parameter int          IRQ_W       = 8,
  parameter logic [31:0] CNT_INIT    = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      core_addr,
  input  logic             core_req,
  input  logic [3:0]       core_be,
  input  logic [31:0]      core_wdata,
  output logic [31:0]      core_rdata,
  output logic             core_stall,
  output logic             core_irq,
  output logic [31:0]      mem_addr,
  output logic             mem_en,
  output logic [3:0]       mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic [IRQ_W-1:0] ext_irq,
  output logic             dbg_valid,
  output logic [7:0]       dbg_char,
  output logic             halt,
  output logic [31:0]      exit_code
`ifdef HFRV_BUS_ALIGN_CHECK_EN
  ,
  output logic             bus_err
`endif
);

  localparam logic [31:0] EXIT_ADDR   = 32'hE000_0000;
  localparam logic [31:0] DEBUG_ADDR  = 32'hF000_00D0;
  localparam logic [31:0] COUNT_ADDR  = 32'hF000_0100;
  localparam logic [31:0] STATUS_ADDR = 32'hF000_0200;
  localparam logic [31:0] MASK_ADDR   = 32'hF000_0210;

  logic [2:0]       wcnt;
  logic [31:0]      count;
  logic [IRQ_W-1:0] irq_status;
  logic [IRQ_W-1:0] irq_mask;

  logic        req_v;
  logic        is_mem;
  logic        last;
  logic        bad;
  logic        pwr;
  logic [31:0] waddr;

  // Reset gates the request so an in-flight access is dropped at once.
  assign req_v  = core_req & rst_n;
  assign is_mem = core_addr < PERIPH_BASE;
  assign waddr  = {core_addr[31:2], 2'b00};
  // wcnt counts stalled cycles of the current memory access.
  assign last   = (wcnt == 3'(MEM_WAIT));

`ifdef HFRV_BUS_ALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (core_be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: misaligned = 1'b0;
      4'b0011, 4'b1100: misaligned = core_addr[0];
      4'b1111:          misaligned = (core_addr[1:0] != 2'b00);
      default:          misaligned = 1'b1;
    endcase
  end
  assign bad     = req_v & misaligned;
  assign bus_err = bad & (~is_mem | last);
`else
  assign bad = 1'b0;
`endif

  // Peripheral write strobe: peripherals complete in the request cycle.
  assign pwr = req_v & ~is_mem & (core_be != 4'b0000) & ~bad;

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 4'b0000;
    core_stall = 1'b0;
    core_rdata = 32'h0;
    mem_addr   = rst_n ? waddr : 32'h0;
    mem_wdata  = rst_n ? core_wdata : 32'h0;
    if (req_v && is_mem) begin
      mem_en     = 1'b1;
      core_stall = ~last;
      if (last) begin
        if (!halt && !bad) mem_we = core_be;
        core_rdata = bad ? 32'hDEAD_BEEF : mem_rdata;
      end
    end else if (req_v) begin
      case (waddr)
        EXIT_ADDR:   core_rdata = exit_code;
        COUNT_ADDR:  core_rdata = count;
        STATUS_ADDR: core_rdata = 32'(irq_status);
        MASK_ADDR:   core_rdata = 32'(irq_mask);
        default:     core_rdata = 32'h0;
      endcase
      if (bad) core_rdata = 32'hDEAD_BEEF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 3'd0;
    end else if (req_v && is_mem && !last) begin
      wcnt <= wcnt + 3'd1;
    end else begin
      // Completion (or idle) rearms the count so back-to-back accesses each wait.
      wcnt <= 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exit_code  <= 32'h0;
      halt       <= 1'b0;
      dbg_valid  <= 1'b0;
      dbg_char   <= 8'h0;
      count      <= CNT_INIT;
      irq_status <= '0;
      irq_mask   <= '0;
      core_irq   <= 1'b0;
    end else begin
      count     <= count + 32'd1;
      dbg_valid <= pwr && (waddr == DEBUG_ADDR) && core_be[0];
      if (pwr && (waddr == DEBUG_ADDR) && core_be[0]) dbg_char <= core_wdata[7:0];
      if (pwr && (waddr == EXIT_ADDR)) begin
        exit_code <= core_wdata;
        halt      <= 1'b1;
      end
      if (pwr && (waddr == MASK_ADDR)) irq_mask <= core_wdata[IRQ_W-1:0];
      // W1C clear first, then OR in live sources so a new event is never lost.
      irq_status <= (irq_status &
                     ~((pwr && (waddr == STATUS_ADDR)) ? core_wdata[IRQ_W-1:0] : '0))
                    | ext_irq;
      core_irq <= |(irq_status & irq_mask);
    end
  end

endmodule

// File: tb/tb_hfrv_bus_bridge.sv
module tb_hfrv_bus_bridge;

  localparam int IRQ_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (MEM_WAIT = 2) ----------------
  logic [31:0]      core_addr = '0;
  logic             core_req = 1'b0;
  logic [3:0]       core_be = '0;
  logic [31:0]      core_wdata = '0;
  logic [31:0]      core_rdata;
  logic             core_stall;
  logic             core_irq;
  logic [31:0]      mem_addr;
  logic             mem_en;
  logic [3:0]       mem_we;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic [IRQ_W-1:0] ext_irq = '0;
  logic             dbg_valid;
  logic [7:0]       dbg_char;
  logic             halt;
  logic [31:0]      exit_code;
`ifdef HFRV_BUS_ALIGN_CHECK_EN
  logic             bus_err;
  logic             w_bus_err;
`endif

  hfrv_bus_bridge #(.MEM_WAIT(2), .PERIPH_BASE(32'hE000_0000), .IRQ_W(IRQ_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_addr(core_addr), .core_req(core_req), .core_be(core_be), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall), .core_irq(core_irq),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ext_irq(ext_irq),
    .dbg_valid(dbg_valid), .dbg_char(dbg_char), .halt(halt), .exit_code(exit_code)
`ifdef HFRV_BUS_ALIGN_CHECK_EN
    , .bus_err(bus_err)
`endif
  );

  // ---------------- second instance: counter preset near wrap ----------------
  localparam logic [31:0] WRAP_INIT = 32'hFFFF_FFF8;
  logic [31:0]      w_rdata, w_maddr, w_mwdata, w_exit;
  logic             w_stall, w_irq, w_men, w_dbgv, w_halt;
  logic [3:0]       w_mwe;
  logic [7:0]       w_dbgc;

  hfrv_bus_bridge #(.MEM_WAIT(0), .PERIPH_BASE(32'hE000_0000), .IRQ_W(IRQ_W),
                    .CNT_INIT(WRAP_INIT)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .core_addr(32'hF000_0100), .core_req(1'b1), .core_be(4'b0000), .core_wdata(32'h0),
    .core_rdata(w_rdata), .core_stall(w_stall), .core_irq(w_irq),
    .mem_addr(w_maddr), .mem_en(w_men), .mem_we(w_mwe), .mem_wdata(w_mwdata),
    .mem_rdata(32'h0), .ext_irq('0),
    .dbg_valid(w_dbgv), .dbg_char(w_dbgc), .halt(w_halt), .exit_code(w_exit)
`ifdef HFRV_BUS_ALIGN_CHECK_EN
    , .bus_err(w_bus_err)
`endif
  );

  // ---------------- external memory model ----------------
  logic [31:0] tbmem   [0:255];
  logic [31:0] ref_mem [0:255];
  logic        preload = 1'b0;

  assign mem_rdata = tbmem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) tbmem[i] <= ref_mem[i];
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) tbmem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // Debug character monitor.
  logic [7:0] dbg_q[$];
  always @(negedge clk) if (dbg_valid) dbg_q.push_back(dbg_char);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 just after the completing edge.
  logic [31:0] a_rd, a_addr;
  logic [3:0]  a_fwe;
  int          a_st, a_ewe, a_en;

  task automatic access(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic done;
    done = 1'b0;
    core_addr = a; core_be = be; core_wdata = wd; core_req = 1'b1;
    a_st = 0; a_ewe = 0; a_en = 0; a_rd = '0; a_fwe = '0; a_addr = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en) a_en++;
      if (core_stall) begin
        a_st++;
        if (mem_we != 4'b0000) a_ewe++;
        @(posedge clk); #1;
      end else begin
        a_rd = core_rdata; a_fwe = mem_we; a_addr = mem_addr;
        done = 1'b1;
        break;
      end
    end
    check("access_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    core_req = 1'b0; core_be = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // ---------------- reference state ----------------
  logic [IRQ_W-1:0] ref_status, ref_mask;
  logic             ref_halt;
  logic [31:0]      w0, c1, c2, e, wd;
  logic [3:0]       be;
  logic [7:0]       pat;
  int               idx;
  logic [3:0]       legal_be [0:8];

  initial begin
    legal_be[0] = 4'b0000; legal_be[1] = 4'b0000; legal_be[2] = 4'b0001;
    legal_be[3] = 4'b0010; legal_be[4] = 4'b0100; legal_be[5] = 4'b1000;
    legal_be[6] = 4'b0011; legal_be[7] = 4'b1100; legal_be[8] = 4'b1111;
    ref_status = '0; ref_mask = '0; ref_halt = 1'b0;

    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[16] = 32'h1234_5678;

    // Reset state
    preload = 1'b1;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_exit_code", exit_code, 32'h0);
    check("rst_dbg_valid", 32'(dbg_valid), 32'd0);
    check("rst_core_irq", 32'(core_irq), 32'd0);
    check("rst_stall", 32'(core_stall), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Counter wrap on the preset instance
    @(negedge clk);
    w0 = w_rdata;
    check("wrap_init", w0, WRAP_INIT);
    repeat (10) @(negedge clk);
    check("wrap_plus10", w_rdata, w0 + 32'd10);
    check("wrap_happened", 32'(w_rdata < 32'h10), 32'd1);
    @(posedge clk); #1;

    // Directed memory read with 2 wait states
    access(32'h0000_0040, 4'b0000, 32'h0);
    check("rd40_stalls", 32'(a_st), 32'd2);
    check("rd40_data", a_rd, 32'h1234_5678);
    check("rd40_en_cycles", 32'(a_en), 32'd3);

    // Directed single-byte write
    access(32'h0000_0100, 4'b0100, 32'h00AB_0000);
    check("wr100_early_we", 32'(a_ewe), 32'd0);
    check("wr100_final_we", 32'(a_fwe), 32'(4'b0100));
    check("wr100_addr", a_addr, 32'h0000_0100);
    ref_mem[64] = merge(ref_mem[64], 32'h00AB_0000, 4'b0100);
    access(32'h0000_0100, 4'b0000, 32'h0);
    check("rd100_data", a_rd, ref_mem[64]);

    // Randomized back-to-back memory traffic against the array model
    for (int k = 0; k < 24; k++) begin
      idx = $urandom_range(0, 255);
      be  = legal_be[$urandom_range(0, 8)];
      wd  = $urandom;
      access({22'h0, 8'(idx), 2'b00} + ((be == 4'b1100) ? 32'd2 : 32'd0), be, wd);
      check("rnd_stalls", 32'(a_st), 32'd2);
      check("rnd_early_we", 32'(a_ewe), 32'd0);
      if (be == 4'b0000) begin
        check("rnd_rdata", a_rd, ref_mem[idx]);
      end else begin
        check("rnd_final_we", 32'(a_fwe), 32'(be));
        ref_mem[idx] = merge(ref_mem[idx], wd, be);
      end
    end
    for (int k = 0; k < 256; k += 37) begin
      access(32'(k) << 2, 4'b0000, 32'h0);
      check("sweep_rdata", a_rd, ref_mem[k]);
    end

    // Debug register
    access(32'hF000_00D0, 4'b0001, 32'h0000_0048);
    check("dbg1_stalls", 32'(a_st), 32'd0);
    @(posedge clk); #1;
    access(32'hF000_00D0, 4'b0001, 32'h0000_0069);
    check("dbg2_stalls", 32'(a_st), 32'd0);
    @(posedge clk); #1;
    access(32'hF000_00D0, 4'b0000, 32'h0);
    check("dbg_read", a_rd, 32'h0);
    check("dbg_pulses", 32'(dbg_q.size()), 32'd2);
    if (dbg_q.size() == 2) begin
      check("dbg_char0", 32'(dbg_q[0]), 32'h48);
      check("dbg_char1", 32'(dbg_q[1]), 32'h69);
    end

    // Unmapped peripheral
    access(32'hF000_0300, 4'b1111, 32'hFFFF_FFFF);
    access(32'hF000_0300, 4'b0000, 32'h0);
    check("unmapped_read", a_rd, 32'h0);
    check("unmapped_stalls", 32'(a_st), 32'd0);

    // Mask register width
    access(32'hF000_0210, 4'b1111, 32'hFFFF_FFFF);
    access(32'hF000_0210, 4'b0000, 32'h0);
    check("mask_upper_zero", a_rd, 32'h0000_00FF);

    // Directed interrupt path
    access(32'hF000_0210, 4'b1111, 32'h0000_0004);
    ref_mask = 8'h04;
    ext_irq = 8'h04;
    @(posedge clk); #1 ext_irq = '0;
    @(negedge clk);
    check("irq_latency", 32'(core_irq), 32'd0);
    @(negedge clk);
    check("irq_asserted", 32'(core_irq), 32'd1);
    @(posedge clk); #1;
    access(32'hF000_0200, 4'b1111, 32'h0000_0004);
    repeat (2) @(posedge clk);
    #1;
    check("irq_cleared", 32'(core_irq), 32'd0);

    // Set beats W1C in the same cycle
    ext_irq = 8'h10;
    @(posedge clk); #1;
    access(32'hF000_0200, 4'b1111, 32'h0000_0010);
    ext_irq = '0;
    access(32'hF000_0200, 4'b0000, 32'h0);
    check("set_wins", a_rd, 32'h0000_0010);
    access(32'hF000_0200, 4'b1111, 32'h0000_0010);

    // Randomized interrupt traffic
    for (int k = 0; k < 6; k++) begin
      ref_mask = 8'($urandom);
      access(32'hF000_0210, 4'b1111, 32'(ref_mask));
      pat = 8'($urandom);
      ext_irq = pat;
      @(posedge clk); #1 ext_irq = '0;
      ref_status = ref_status | pat;
      access(32'hF000_0200, 4'b0000, 32'h0);
      check("rnd_status", a_rd, 32'(ref_status));
      @(posedge clk); #1;
      check("rnd_core_irq", 32'(core_irq), 32'(|(ref_status & ref_mask)));
      wd = 32'($urandom);
      access(32'hF000_0200, 4'b1111, wd);
      ref_status = ref_status & ~wd[7:0];
    end

    // Counter difference
    access(32'hF000_0100, 4'b0000, 32'h0);
    c1 = a_rd;
    repeat (9) @(posedge clk);
    #1;
    access(32'hF000_0100, 4'b1111, 32'h0);
    c2 = a_rd;
    check("count_diff", c2 - c1, 32'd10);

    // Exit / halt
    e = $urandom;
    access(32'hE000_0000, 4'b1111, e);
    ref_halt = 1'b1;
    check("exit_code_val", exit_code, e);
    check("halt_set", 32'(halt), 32'(ref_halt));
    access(32'hE000_0000, 4'b0000, 32'h0);
    check("exit_read", a_rd, e);
    access(32'hE000_0000, 4'b1111, 32'h0);
    check("exit_code_zero", exit_code, 32'h0);
    check("halt_sticky", 32'(halt), 32'd1);
    access(32'h0000_0080, 4'b1111, 32'hCAFE_F00D);
    check("halted_we", 32'(a_fwe), 32'h0);
    access(32'h0000_0080, 4'b0000, 32'h0);
    check("halted_read", a_rd, ref_mem[32]);

    // Reset in the middle of a stalled write
    core_addr = 32'h0000_0200; core_be = 4'b1111; core_wdata = 32'h5555_AAAA; core_req = 1'b1;
    @(negedge clk);
    check("midrst_stall_before", 32'(core_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_stall", 32'(core_stall), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_en", 32'(mem_en), 32'd0);
    check("midrst_halt", 32'(halt), 32'd0);
    core_req = 1'b0; core_be = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    access(32'h0000_0200, 4'b0000, 32'h0);
    check("midrst_nowrite", a_rd, ref_mem[128]);
    check("midrst_stalls_after", 32'(a_st), 32'd2);
    access(32'h0000_0200, 4'b1111, 32'h1357_9BDF);
    check("post_rst_we", 32'(a_fwe), 32'hF);
    ref_mem[128] = 32'h1357_9BDF;
    access(32'h0000_0200, 4'b0000, 32'h0);
    check("post_rst_read", a_rd, ref_mem[128]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
